booth_mult: RTL and testbench
=============================

# booth_mult

Sequential signed 32×32→64 multiplier (radix-2 Booth, one step per clock) feeding the CPU's Hi/Lo registers through the MDSelect mux. The control unit pulses `start` in the multiply state, stalls until `done`, then asserts HiCtrl/LoCtrl to capture `hi_out`/`lo_out`. Operands come straight from the A and B registers. Results stay stable until the next completed operation, so the control unit may capture them any cycle after `done`.

## Interface
- `WIDTH`, 32, operand width; result is 2·WIDTH.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; one clock, one synchronous active-high reset.
- `start`  in  1  request; sampled only when not busy.
- `a_in`  in  WIDTH  multiplicand (signed, two's complement).
- `b_in`  in  WIDTH  multiplier (signed, two's complement).
- `hi_out`  out  WIDTH  product[63:32]; reset 0.
- `lo_out`  out  WIDTH  product[31:0]; reset 0.
- `busy`  out  1  high while an operation is in progress; reset 0.
- `done`  out  1  one-cycle pulse when `hi_out`/`lo_out` take a new result; reset 0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, `start`=1: load M←a_in, acc←33'b0, q←b_in, q_1←0, step count←0; go to RUN. IDLE, `start`=0: stay.
- RUN, each cycle, one Booth step:
  - {q[0],q_1}=01: acc←acc+sext33(M).
  - {q[0],q_1}=10: acc←acc−sext33(M).
  - 00/11: acc unchanged.
  - Then arithmetic right shift of {acc,q,q_1} by 1; acc MSB replicates.
  - Count increments.
- After step WIDTH (count reaches WIDTH−1 and its step completes): load hi_out←acc[31:0], lo_out←q; go to DONE.
- DONE: `done`=1 for this cycle only.
  - `start`=1 in DONE: accepted as in IDLE; go straight to RUN.
  - Otherwise go to IDLE.
- 33-bit accumulator is mandatory: it makes M=0x80000000 (subtracting −2^31) exact. Product is exact for all operand pairs; no overflow flag.
- `start` in RUN is ignored. No queueing and no abort.
- `a_in`/`b_in` are captured only at acceptance. Later changes have no effect on the running operation.
- `hi_out`/`lo_out` hold the previous result throughout RUN; intermediate values are never visible.
- `busy`=1 in RUN, 0 in IDLE and DONE.
- `reset` in any state: IDLE, all outputs 0, internal registers 0, no `done` pulse.
  - `reset` with `start` in the same cycle: reset wins.

## Timing
- Accept edge E (IDLE/DONE, `start`=1): `busy` rises after E.
- Steps occur on edges E+1 … E+32.
- On edge E+32: `hi_out`/`lo_out` update, `busy` falls, `done` rises.
- `done` is high during the cycle after E+32 only.
- Latency: 32 cycles from accept edge to result; throughput one multiply per 33 cycles.
- Back-to-back: `start` held high in the DONE cycle starts the next operation with no idle cycle between operations.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared `cpu_pkg`:
  - State encoding `mult_state_t` (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - Constant `MULT_STEPS`=32.
  - 2'd3 is illegal and recovers to IDLE on the next edge.
- Sub-module `booth_step`: combinational. Inputs {acc,q,q_1} and M; output the next {acc,q,q_1} (add/sub plus arithmetic shift). Verified standalone.
- Counter width $clog2(MULT_STEPS).

## Test plan
- a=3, b=5, `start` pulse in IDLE: `busy` for 32 cycles; `done` one cycle at E+32; hi=0x00000000, lo=0x0000000F.
- a=0xFFFFFFFF (−1), b=1: hi=0xFFFFFFFF, lo=0xFFFFFFFF.
- a=b=0x80000000: hi=0x40000000, lo=0x00000000. a=b=0x7FFFFFFF: hi=0x3FFFFFFF, lo=0x00000001.
- First op 7×6 running; at cycle 5 pulse `start` with a=2, b=2; change a_in every cycle. Required: result 0/0x2A at E+32, no second operation, previous outputs held during RUN.
- `start` held high continuously with a=−2, b=3, then a=4, b=4 at the DONE cycle. Required: first result 0xFFFFFFFF/0xFFFFFFFA; second accepted in DONE with `done` again 32 cycles later and result 0/0x10.
- `reset` asserted at step 10 of 9×9: next cycle `busy`=0, hi=lo=0, no `done` pulse. Next `start` with 9×9 then completes normally with lo=0x51.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the multiply/divide datapath.
//   mult_state_t : control state of the sequential Booth multiplier
//   MULT_STEPS   : Booth steps per multiply (one per operand bit)
//   MULT_CNT_W   : width of the step counter
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  localparam int MULT_STEPS = 32;
  localparam int MULT_CNT_W = $clog2(MULT_STEPS);

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth step, purely combinational.
//   acc_i/q_i/q1_i : current {acc,q,q_1} partial-product state
//   m_i            : multiplicand M (signed)
//   acc_o/q_o/q1_o : state after add/sub of M and a 1-bit arithmetic right shift
module booth_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   acc_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic             q1_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH:0]   acc_o,
  output logic [WIDTH-1:0] q_o,
  output logic             q1_o
);

  logic [WIDTH:0] m_ext;
  logic [WIDTH:0] sum;

  always_comb begin
    // Accumulator is one bit wider than M so that subtracting -2^(WIDTH-1)
    // cannot overflow.
    m_ext = {m_i[WIDTH-1], m_i};
    case ({q_i[0], q1_i})
      2'b01:   sum = acc_i + m_ext;
      2'b10:   sum = acc_i - m_ext;
      default: sum = acc_i;
    endcase
    // Arithmetic right shift of {sum,q,q_1}: sum MSB replicates, sum LSB
    // moves into q, q LSB moves into q_1.
    acc_o = {sum[WIDTH], sum[WIDTH:1]};
    q_o   = {sum[0], q_i[WIDTH-1:1]};
    q1_o  = q_i[0];
  end

endmodule

// File: rtl/booth_mult.sv
// Sequential signed WIDTH x WIDTH -> 2*WIDTH radix-2 Booth multiplier,
// one Booth step per clock, feeding the CPU Hi/Lo registers.
//   clk    : system clock
//   reset  : synchronous active-high reset
//   start  : operation request, sampled only in IDLE/DONE
//   a_in   : multiplicand (signed), captured at acceptance
//   b_in   : multiplier (signed), captured at acceptance
//   hi_out : product upper half, held until the next completed operation
//   lo_out : product lower half, held until the next completed operation
//   busy   : high while a multiply is running
//   done   : one-cycle pulse when hi_out/lo_out take a new result
// WIDTH is expected to equal MULT_STEPS.
module booth_mult
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done
);

  mult_state_t           state_q, state_d;
  logic [WIDTH-1:0]      m_q, m_d;
  logic [WIDTH:0]        acc_q, acc_d;
  logic [WIDTH-1:0]      q_q, q_d;
  logic                  q1_q, q1_d;
  logic [MULT_CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]      hi_q, hi_d;
  logic [WIDTH-1:0]      lo_q, lo_d;

  logic [WIDTH:0]        step_acc;
  logic [WIDTH-1:0]      step_q;
  logic                  step_q1;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc_i (acc_q),
    .q_i   (q_q),
    .q1_i  (q1_q),
    .m_i   (m_q),
    .acc_o (step_acc),
    .q_o   (step_q),
    .q1_o  (step_q1)
  );

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      // DONE accepts a new request exactly like IDLE so that a held start
      // gives back-to-back operations without a bubble.
      IDLE, DONE: begin
        if (start) begin
          m_d     = a_in;
          acc_d   = '0;
          q_d     = b_in;
          q1_d    = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d = step_acc;
        q_d   = step_q;
        q1_d  = step_q1;
        cnt_d = cnt_q + MULT_CNT_W'(1);
        // Results are published only from the final step, so the outputs
        // keep the previous product for the whole run.
        if (cnt_q == MULT_CNT_W'(MULT_STEPS - 1)) begin
          hi_d    = step_acc[WIDTH-1:0];
          lo_d    = step_q;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi_out = hi_q;
  assign lo_out = lo_q;
  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);

endmodule

// File: tb/tb_booth_mult.sv
// Scoreboard bench for booth_mult: a cycle-level reference model pushes the
// exact signed product on every accepted request; a negedge monitor pops it
// on each done pulse and checks busy/done/hold behaviour every cycle.
module tb_booth_mult;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  booth_mult #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a_in   (a_in),
    .b_in   (b_in),
    .hi_out (hi_out),
    .lo_out (lo_out),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [63:0] exp_q[$];
  int          m_cnt  = 0;     // remaining steps of the running operation
  logic        m_done = 1'b0;  // expected done pulse this cycle
  logic        m_rst  = 1'b0;  // reset was applied at the last edge
  logic        mon_en = 1'b0;
  logic [63:0] last_res = '0;

  function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a request is taken whenever no operation is running,
  // and its product appears 32 edges later.
  always @(posedge clk) begin
    m_rst <= reset;
    if (reset) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
      exp_q.delete();
    end else begin
      m_done <= 1'b0;
      if (m_cnt == 0) begin
        if (start) begin
          exp_q.push_back(prod(a_in, b_in));
          m_cnt <= 32;
        end
      end else begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) m_done <= 1'b1;
      end
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (mon_en) begin
      logic [63:0] e;
      if (m_rst) last_res = '0;
      chk("busy", 64'(busy), 64'(m_cnt != 0));
      chk("done", 64'(done), 64'(m_done));
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL result_unexpected actual=%h_%h expected=none", hi_out, lo_out);
        end else begin
          e = exp_q.pop_front();
          chk("result", {hi_out, lo_out}, e);
          $display("result a*b -> %h_%h expected %h", hi_out, lo_out, e);
          last_res = e;
        end
      end else begin
        chk("held", {hi_out, lo_out}, last_res);
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 100 && m_cnt != 0; i++) @(negedge clk);
    if (m_cnt != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout actual=busy expected=idle");
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit wiggle);
    @(negedge clk);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    $display("issue a=%h b=%h", a, b);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100 && m_cnt != 0; i++) begin
      if (wiggle) begin
        a_in  = $urandom;
        b_in  = $urandom;
        // Requests while running must be ignored.
        start = (m_cnt > 1) && (i == 5 || $urandom_range(0, 3) == 0);
      end
      @(negedge clk);
    end
    start = 1'b0;
    wait_idle();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (3) @(negedge clk);
    chk("reset_hi", 64'(hi_out), 64'd0);
    chk("reset_lo", 64'(lo_out), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    mon_en = 1'b1;
    reset  = 1'b0;

    // Directed operand pairs
    run_op(32'd3, 32'd5, 1'b0);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
    // Inputs and start toggling during RUN
    run_op(32'd7, 32'd6, 1'b1);
    chk("ignore_start_lo", 64'(lo_out), 64'h2A);

    // start held high: second request accepted in the DONE cycle
    @(negedge clk);
    start = 1'b1;
    a_in  = 32'hFFFF_FFFE;
    b_in  = 32'd3;
    for (int i = 0; i < 100 && !m_done; i++) @(negedge clk);
    chk("b2b_first_done", 64'(done), 64'd1);
    a_in = 32'd4;
    b_in = 32'd4;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_second_busy", 64'(busy), 64'd1);
    wait_idle();
    chk("b2b_second_lo", 64'(lo_out), 64'h10);

    // Reset in the middle of an operation
    @(negedge clk);
    start = 1'b1;
    a_in  = 32'd9;
    b_in  = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_busy", 64'(busy), 64'd0);
    chk("midreset_hi", 64'(hi_out), 64'd0);
    chk("midreset_lo", 64'(lo_out), 64'd0);
    chk("midreset_done", 64'(done), 64'd0);
    run_op(32'd9, 32'd9, 1'b0);
    chk("after_reset_lo", 64'(lo_out), 64'h51);

    // Random operands with random gaps
    for (int k = 0; k < 20; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_op(pick(), pick(), bit'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
